// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter
// Shares one line-wide lower-level memory port between the I-cache and the
// D-cache. One line transaction is in flight at a time. Simultaneous requests
// are resolved round-robin: the side that was not granted last wins. The winning
// request is latched at grant, so the memory side sees a stable address,
// write flag and write line until mem_resp, whatever the requesters do meanwhile.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   i_read, i_address               I-cache line read request (held until i_resp)
//   i_rdata, i_resp                 line and one-cycle completion to the I-cache
//   d_read, d_write, d_address,     D-cache read / writeback request (held until d_resp)
//   d_wdata
//   d_rdata, d_resp                 line and one-cycle completion to the D-cache
//   mem_read, mem_write,            lower-level strobes, line-aligned address and
//   mem_address, mem_wdata          write line
//   mem_rdata, mem_resp             lower-level read line and single-cycle completion
module lc3b_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128,
    parameter int OFF_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              last_grant;   // 0: I-cache granted last, 1: D-cache
    logic [ADDR_W-1:0] lat_addr;
    logic [LINE_W-1:0] lat_wdata;
    logic              lat_write;

    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;

    assign i_req = i_read;
    // A D-cache request with both read and write set is a writeback.
    assign d_req = d_read | d_write;

    // Address and write line come straight from the latches.
    assign mem_address = lat_addr;
    assign mem_wdata   = lat_wdata;

    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        i_rdata    = '0;
        d_rdata    = '0;

        unique case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    // Tie: hand the port to the side that did not have it last.
                    if (last_grant) grant_i = 1'b1;
                    else            grant_d = 1'b1;
                end else if (i_req) begin
                    grant_i = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end

                if (grant_i) state_next = SERVE_I;
                if (grant_d) state_next = SERVE_D;
            end

            SERVE_I: begin
                mem_read  = ~lat_write;
                mem_write = lat_write;
                // A completion arriving while reset is held abandons the transaction.
                if (mem_resp && !rst) begin
                    i_resp     = 1'b1;
                    if (!lat_write) i_rdata = mem_rdata;
                    state_next = IDLE;
                end
            end

            SERVE_D: begin
                mem_read  = ~lat_write;
                mem_write = lat_write;
                if (mem_resp && !rst) begin
                    d_resp     = 1'b1;
                    if (!lat_write) d_rdata = mem_rdata;
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_write  <= 1'b0;
        end else begin
            state <= state_next;
            if (grant_i) begin
                lat_addr   <= {i_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                lat_write  <= 1'b0;
                last_grant <= 1'b0;
            end
            if (grant_d) begin
                lat_addr   <= {d_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                lat_wdata  <= d_wdata;
                lat_write  <= d_write;
                last_grant <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Testbench for lc3b_mem_arbiter: directed scenarios followed by randomized
// requester / memory traffic, checked cycle by cycle against a transaction-level
// reference model.
module tb_lc3b_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;
    localparam int OFF_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    lc3b_mem_arbiter #(
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W),
        .OFF_W (OFF_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_read     (i_read),
        .i_address  (i_address),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_address  (d_address),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: which requester owns the port (0 none, 1 I, 2 D), the
    // transaction it was granted, and who won the previous grant.
    int                cur_owner = 0;
    bit                last_was_d = 0;
    logic [ADDR_W-1:0] tx_addr;
    logic [LINE_W-1:0] tx_wdata;
    bit                tx_write;
    bit                exp_i_resp;
    bit                exp_d_resp;
    bit                obs_i_resp;
    bit                obs_d_resp;

    // Called at a falling edge with this cycle's inputs already applied.
    // Checks the outputs, advances the model across the next rising edge and
    // returns at the following falling edge.
    task automatic step();
        bit                e_mr, e_mw;
        logic [LINE_W-1:0] e_ird, e_drd;
        bit                ireq, dreq, take_d;
        #1;
        e_mr  = (cur_owner != 0) && !tx_write;
        e_mw  = (cur_owner != 0) && tx_write;
        exp_i_resp = (cur_owner == 1) && mem_resp && !rst;
        exp_d_resp = (cur_owner == 2) && mem_resp && !rst;
        e_ird = exp_i_resp ? mem_rdata : '0;
        e_drd = (exp_d_resp && !tx_write) ? mem_rdata : '0;
        chk("mem_read",  mem_read,  e_mr);
        chk("mem_write", mem_write, e_mw);
        chk("i_resp",    i_resp,    exp_i_resp);
        chk("d_resp",    d_resp,    exp_d_resp);
        chk("i_rdata",   i_rdata,   e_ird);
        chk("d_rdata",   d_rdata,   e_drd);
        if (cur_owner != 0) begin
            chk("mem_address", mem_address, tx_addr);
            if (tx_write) chk("mem_wdata", mem_wdata, tx_wdata);
        end
        obs_i_resp = i_resp;
        obs_d_resp = d_resp;

        if (rst) begin
            cur_owner  = 0;
            last_was_d = 0;
        end else if (cur_owner != 0) begin
            if (mem_resp) cur_owner = 0;
        end else begin
            ireq = i_read;
            dreq = d_read || d_write;
            take_d = (ireq && dreq) ? !last_was_d : dreq;
            if (ireq || dreq) begin
                if (take_d) begin
                    cur_owner  = 2;
                    tx_addr    = d_address - (d_address % 16);
                    tx_write   = d_write;
                    tx_wdata   = d_wdata;
                    last_was_d = 1;
                end else begin
                    cur_owner  = 1;
                    tx_addr    = i_address - (i_address % 16);
                    tx_write   = 0;
                    last_was_d = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, limit 2000000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] order;
        int         n_grants;
        bit         i_pend, d_pend;
        int         kind;

        rst = 1; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
        d_address = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 0;

        // Reset, then idle with a stray memory completion.
        @(negedge clk);
        step();
        rst = 0;
        for (int c = 0; c < 10; c++) begin
            mem_resp = (c == 3);
            mem_rdata = {4{32'h1357_9BDF}};
            step();
        end
        mem_resp = 0;
        chk("reset_mem_address", mem_address, '0);
        chk("reset_mem_wdata",   mem_wdata,   '0);

        // I-cache read, memory answers on the third strobe cycle.
        i_read = 1; i_address = 16'h1236;
        mem_rdata = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A501;
        step();
        i_address = 16'hFFFF;
        step();
        step();
        mem_resp = 1;
        step();
        chk("i_read_done", obs_i_resp, 1'b1);
        i_read = 0; mem_resp = 0;
        step();

        // D-cache writeback; requester inputs change after the grant.
        d_write = 1; d_address = 16'h4008;
        d_wdata = 128'hDEADBEEF_01234567_89ABCDEF_CAFEBEEF;
        step();
        d_address = 16'h0000; d_wdata = '0; d_write = 1;
        step();
        step();
        mem_resp = 1;
        step();
        chk("d_write_done", obs_d_resp, 1'b1);
        d_write = 0; mem_resp = 0;
        step();

        // Both sides requesting from reset: grants must go D, I, D, I.
        rst = 1;
        step();
        rst = 0;
        i_read = 1; i_address = 16'h2220; d_read = 1; d_address = 16'h3330;
        order = '0; n_grants = 0;
        for (int c = 0; c < 20 && n_grants < 4; c++) begin
            mem_resp = mem_read || mem_write;
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            step();
            if (obs_d_resp) begin order = {order[5:0], 2'd2}; n_grants++; end
            if (obs_i_resp) begin order = {order[5:0], 2'd1}; n_grants++; end
            // Finished side drops for one cycle, then asks again.
            i_read = !obs_i_resp;
            d_read = !obs_d_resp;
        end
        chk("tie_order", order, 8'b10_01_10_01);
        i_read = 0; d_read = 0; mem_resp = 0;
        step();

        // Reset mid-wait with a coincident completion, then a fresh I read.
        d_read = 1; d_address = 16'h5555;
        step();
        step();
        rst = 1; mem_resp = 1;
        step();
        chk("rst_no_d_resp", obs_d_resp, 1'b0);
        rst = 0; mem_resp = 0; d_read = 0;
        step();
        i_read = 1; i_address = 16'h0ABC;
        mem_rdata = {4{32'h0F0F_1234}};
        step();
        mem_resp = 1;
        step();
        chk("after_rst_i_done", obs_i_resp, 1'b1);
        i_read = 0; mem_resp = 0;
        step();

        // Read and write together is a writeback.
        d_read = 1; d_write = 1; d_address = 16'h7777;
        d_wdata = {4{32'h8000_0001}};
        step();
        mem_resp = 1;
        step();
        d_read = 0; d_write = 0; mem_resp = 0;
        step();

        // Randomized traffic.
        i_pend = 0; d_pend = 0;
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            mem_resp  = ($urandom_range(0, 2) == 0);
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            i_address = ADDR_W'($urandom);
            d_address = ADDR_W'($urandom);
            d_wdata   = {$urandom, $urandom, $urandom, $urandom};
            if (!i_pend) i_pend = ($urandom_range(0, 2) == 0);
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1;
                kind = int'($urandom_range(0, 2));
                d_read  = (kind != 1);
                d_write = (kind != 0);
            end
            i_read = i_pend;
            if (!d_pend) begin d_read = 0; d_write = 0; end
            step();
            if (exp_i_resp) i_pend = 0;
            if (exp_d_resp) d_pend = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
